// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types for mem_port_arbiter.
//   arb_state_t    - arbiter FSM states
//   grant_idx_t    - index of the upstream port that owns the downstream port
//   LAST_GRANT_RST - lastGrant value out of reset, so port 0 wins the first tie
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DONE    = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    typedef logic grant_idx_t;

    localparam grant_idx_t LAST_GRANT_RST = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_grant2.sv
// rr_grant2: combinational 2-way round-robin picker.
//   req[1:0]   - pending requests
//   lastGrant  - port granted most recently
//   grantIdx   - selected port (only meaningful when grantValid)
//   grantValid - at least one request pending
import mem_arb_pkg::*;

module rr_grant2 (
    input  logic [1:0] req,
    input  grant_idx_t lastGrant,
    output grant_idx_t grantIdx,
    output logic       grantValid
);

    always_comb begin
        grantValid = |req;
        // On a tie the port that did not go last wins; otherwise the sole requester.
        if (&req) grantIdx = ~lastGrant;
        else      grantIdx = req[1];
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one lower-level memory port between two upstream
// clients using the level-held enable / complete handshake on both sides.
// Round-robin grant, one transaction in flight. Downstream enable is dropped
// for at least one cycle between transactions so the lower level resets.
//
// Ports:
//   clock, reset                 - single clock, synchronous active-high reset
//   addrIn0/1, dataUpIn0/1,
//   writeIn0/1, enableIn0/1      - upstream requests
//   dataUpOut0/1, complete0/1    - upstream responses
//   addrOut, dataDownOut,
//   writeOut, enableOut          - downstream request
//   dataDownIn, fetchReceive,
//   writeCompleteIn              - downstream response
//   timeoutErr                   - one-cycle pulse on watchdog expiry
//
// Optional: define ARB_TIMEOUT_EN to add a BUSY watchdog of TIMEOUT_CYCLES
// cycles and the timeoutErr port. Without it BUSY waits indefinitely.
import mem_arb_pkg::*;

module mem_port_arbiter #(
    parameter int ADDR_LENGTH    = 10,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ADDR_LENGTH-1:0] addrIn0,
    input  logic [ADDR_LENGTH-1:0] addrIn1,
    input  logic [DATA_WIDTH-1:0]  dataUpIn0,
    input  logic [DATA_WIDTH-1:0]  dataUpIn1,
    input  logic                   writeIn0,
    input  logic                   writeIn1,
    input  logic                   enableIn0,
    input  logic                   enableIn1,
    output logic [DATA_WIDTH-1:0]  dataUpOut0,
    output logic [DATA_WIDTH-1:0]  dataUpOut1,
    output logic                   complete0,
    output logic                   complete1,
    output logic [ADDR_LENGTH-1:0] addrOut,
    output logic [DATA_WIDTH-1:0]  dataDownOut,
    output logic                   writeOut,
    output logic                   enableOut,
    input  logic [DATA_WIDTH-1:0]  dataDownIn,
    input  logic                   fetchReceive,
    input  logic                   writeCompleteIn
`ifdef ARB_TIMEOUT_EN
    ,
    output logic                   timeoutErr
`endif
);

    if (TIMEOUT_CYCLES < 1) begin : gBadTimeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    // Upstream ports gathered into indexable arrays so the owner can select.
    logic [1:0][ADDR_LENGTH-1:0] addrIn;
    logic [1:0][DATA_WIDTH-1:0]  dataUpIn;
    logic [1:0]                  writeIn;
    logic [1:0]                  enableIn;

    assign addrIn   = {addrIn1, addrIn0};
    assign dataUpIn = {dataUpIn1, dataUpIn0};
    assign writeIn  = {writeIn1, writeIn0};
    assign enableIn = {enableIn1, enableIn0};

    arb_state_t state, stateNext;
    grant_idx_t lastGrant, lastGrantNext;
    grant_idx_t pickIdx;
    logic       pickValid;

    logic [1:0][DATA_WIDTH-1:0] dataUpReg, dataUpNext;
    logic [1:0]                 completeReg, completeNext;
    logic [ADDR_LENGTH-1:0]     addrNext;
    logic [DATA_WIDTH-1:0]      dataDownNext;
    logic                       writeNext;
    logic                       enableNext;

    // lastGrant doubles as the current owner while a transaction is live.
    logic respDone;
    logic abortReq;
    logic timeoutHit;

    assign respDone = writeOut ? writeCompleteIn : fetchReceive;
    assign abortReq = ~enableIn[lastGrant];

    rr_grant2 uPick (
        .req        (enableIn),
        .lastGrant  (lastGrant),
        .grantIdx   (pickIdx),
        .grantValid (pickValid)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] toCnt;
    logic             timeoutErrNext;

    // Counts BUSY cycles starting at 0 in the first one; the hit fires in
    // the TIMEOUT_CYCLES-th BUSY cycle, which always leaves BUSY.
    always_ff @(posedge clock) begin
        if (reset || state != BUSY) toCnt <= '0;
        else                        toCnt <= toCnt + CNT_W'(1);
    end

    assign timeoutHit = (state == BUSY) && (toCnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeoutHit = 1'b0;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (pickValid) stateNext = BUSY;
            BUSY: begin
                // A requester that walks away wins over a same-cycle response.
                if (abortReq)                    stateNext = RELEASE;
                else if (respDone || timeoutHit) stateNext = DONE;
            end
            DONE:    if (abortReq) stateNext = RELEASE;
            RELEASE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Output logic: next values for all registered outputs
    always_comb begin
        lastGrantNext = lastGrant;
        addrNext      = addrOut;
        dataDownNext  = dataDownOut;
        writeNext     = writeOut;
        enableNext    = enableOut;
        dataUpNext    = dataUpReg;
        completeNext  = completeReg;
`ifdef ARB_TIMEOUT_EN
        timeoutErrNext = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (pickValid) begin
                    lastGrantNext = pickIdx;
                    addrNext      = addrIn[pickIdx];
                    dataDownNext  = dataUpIn[pickIdx];
                    writeNext     = writeIn[pickIdx];
                    enableNext    = 1'b1;
                end
            end
            BUSY: begin
                if (abortReq) begin
                    enableNext = 1'b0;
                end else if (respDone) begin
                    enableNext              = 1'b0;
                    completeNext[lastGrant] = 1'b1;
                    if (!writeOut) dataUpNext[lastGrant] = dataDownIn;
                end else if (timeoutHit) begin
                    enableNext              = 1'b0;
                    completeNext[lastGrant] = 1'b1;
                    dataUpNext[lastGrant]   = '0;
`ifdef ARB_TIMEOUT_EN
                    timeoutErrNext          = 1'b1;
`endif
                end
            end
            DONE: begin
                if (abortReq) completeNext[lastGrant] = 1'b0;
            end
            RELEASE: begin
                enableNext = 1'b0;
            end
            default: begin
                enableNext   = 1'b0;
                completeNext = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lastGrant   <= LAST_GRANT_RST;
            addrOut     <= '0;
            dataDownOut <= '0;
            writeOut    <= 1'b0;
            enableOut   <= 1'b0;
            dataUpReg   <= '0;
            completeReg <= '0;
        end else begin
            lastGrant   <= lastGrantNext;
            addrOut     <= addrNext;
            dataDownOut <= dataDownNext;
            writeOut    <= writeNext;
            enableOut   <= enableNext;
            dataUpReg   <= dataUpNext;
            completeReg <= completeNext;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (reset) timeoutErr <= 1'b0;
        else       timeoutErr <= timeoutErrNext;
    end
`endif

    assign dataUpOut0 = dataUpReg[0];
    assign dataUpOut1 = dataUpReg[1];
    assign complete0  = completeReg[0];
    assign complete1  = completeReg[1];

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 64;
`ifdef ARB_TIMEOUT_EN
    localparam int TO = 20;
`else
    localparam int TO = 255;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] addrIn0 = '0, addrIn1 = '0;
    logic [DW-1:0] dataUpIn0 = '0, dataUpIn1 = '0;
    logic          writeIn0 = 1'b0, writeIn1 = 1'b0;
    logic          enableIn0 = 1'b0, enableIn1 = 1'b0;
    logic [DW-1:0] dataUpOut0, dataUpOut1;
    logic          complete0, complete1;
    logic [AW-1:0] addrOut;
    logic [DW-1:0] dataDownOut;
    logic          writeOut, enableOut;
    logic [DW-1:0] dataDownIn = '0;
    logic          fetchReceive = 1'b0;
    logic          writeCompleteIn = 1'b0;
`ifdef ARB_TIMEOUT_EN
    logic          timeoutErr;
`endif

    mem_port_arbiter #(
        .ADDR_LENGTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset(reset),
        .addrIn0(addrIn0), .addrIn1(addrIn1),
        .dataUpIn0(dataUpIn0), .dataUpIn1(dataUpIn1),
        .writeIn0(writeIn0), .writeIn1(writeIn1),
        .enableIn0(enableIn0), .enableIn1(enableIn1),
        .dataUpOut0(dataUpOut0), .dataUpOut1(dataUpOut1),
        .complete0(complete0), .complete1(complete1),
        .addrOut(addrOut), .dataDownOut(dataDownOut),
        .writeOut(writeOut), .enableOut(enableOut),
        .dataDownIn(dataDownIn), .fetchReceive(fetchReceive),
        .writeCompleteIn(writeCompleteIn)
`ifdef ARB_TIMEOUT_EN
        , .timeoutErr(timeoutErr)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        int            port;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] expUp [2];
    int            errors = 0;
    int            checks = 0;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic doReset();
        reset = 1'b1;
        enableIn0 = 1'b0; enableIn1 = 1'b0;
        fetchReceive = 1'b0; writeCompleteIn = 1'b0;
        tick(); tick();
        reset = 1'b0;
        expUp[0] = '0; expUp[1] = '0;
    endtask

    task automatic waitEnable(output int cyc, output bit ok);
        cyc = 0; ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            tick();
            cyc++;
            ok = enableOut;
        end
    endtask

    // Scoreboard monitor: every rising complete must match the oldest expectation.
    initial begin
        logic [1:0] prev;
        logic [1:0] cpl;
        exp_t       e;
        prev = '0;
        forever begin
            @(negedge clock);
            cpl = {complete1, complete0};
            if (reset) prev = '0;
            else begin
                for (int p = 0; p < 2; p++) begin
                    if (cpl[p] && !prev[p]) begin
                        checks++;
                        if (sb.size() == 0) begin
                            errors++;
                            $display("FAIL sb_unexpected_complete port=%0d at %0t", p, $time);
                        end else begin
                            e = sb.pop_front();
                            if (e.port != p || (p == 0 ? dataUpOut0 : dataUpOut1) !== e.data) begin
                                errors++;
                                $display("FAIL sb_complete got port=%0d data=%h want port=%0d data=%h",
                                         p, (p == 0 ? dataUpOut0 : dataUpOut1), e.port, e.data);
                            end
                        end
                    end
                end
                prev = cpl;
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({enableOut, writeOut, complete0, complete1} !== 4'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 0000", {enableOut, writeOut, complete0, complete1});
        end
        checks++;
        if (addrOut !== '0 || dataDownOut !== '0) begin
            errors++; $display("FAIL reset_down got addr=%h data=%h want 0", addrOut, dataDownOut);
        end
        checks++;
        if (dataUpOut0 !== '0 || dataUpOut1 !== '0) begin
            errors++; $display("FAIL reset_up got %h %h want 0", dataUpOut0, dataUpOut1);
        end
`ifdef ARB_TIMEOUT_EN
        checks++;
        if (timeoutErr !== 1'b0) begin
            errors++; $display("FAIL reset_timeoutErr got %b want 0", timeoutErr);
        end
`endif
        reset = 1'b0;
        expUp[0] = '0; expUp[1] = '0;
        tick();
        checks++;
        if (enableOut !== 1'b0) begin
            errors++; $display("FAIL idle_enable got %b want 0", enableOut);
        end
    endtask

    task automatic test_single_read();
        bit sawCpl;
        addrIn0 = 10'h004; writeIn0 = 1'b0; enableIn0 = 1'b1;
        tick();
        checks++;
        if (enableOut !== 1'b1 || addrOut !== 10'h004 || writeOut !== 1'b0) begin
            errors++; $display("FAIL read_grant got en=%b addr=%h wr=%b want 1 004 0", enableOut, addrOut, writeOut);
        end
        sawCpl = 1'b0;
        repeat (9) begin
            tick();
            sawCpl |= complete0 | complete1 | ~enableOut;
        end
        checks++;
        if (sawCpl) begin
            errors++; $display("FAIL read_wait got early complete or enable drop");
        end
        dataDownIn = 64'h0123_4567_89AB_CDEF;
        fetchReceive = 1'b1;
        sb.push_back('{port: 0, data: 64'h0123_4567_89AB_CDEF});
        expUp[0] = 64'h0123_4567_89AB_CDEF;
        tick();
        fetchReceive = 1'b0;
        checks++;
        if (complete0 !== 1'b1 || dataUpOut0 !== 64'h0123_4567_89AB_CDEF || enableOut !== 1'b0 || complete1 !== 1'b0) begin
            errors++; $display("FAIL read_done got c0=%b d=%h en=%b c1=%b", complete0, dataUpOut0, enableOut, complete1);
        end
        tick();
        checks++;
        if (complete0 !== 1'b1) begin
            errors++; $display("FAIL read_hold got complete0=%b want 1", complete0);
        end
        enableIn0 = 1'b0;
        tick();
        checks++;
        if (complete0 !== 1'b0 || enableOut !== 1'b0) begin
            errors++; $display("FAIL read_release got c0=%b en=%b want 0 0", complete0, enableOut);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int cyc;
        bit ok;
        int p;
        logic [DW-1:0] d;
        doReset();
        addrIn0 = 10'h010; addrIn1 = 10'h020;
        writeIn0 = 1'b0; writeIn1 = 1'b0;
        enableIn0 = 1'b1; enableIn1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            p = k % 2;
            waitEnable(cyc, ok);
            checks++;
            if (!ok || cyc != (k == 0 ? 1 : 2)) begin
                errors++; $display("FAIL rr_gap k=%0d got ok=%0d cycles=%0d want %0d", k, ok, cyc, (k == 0 ? 1 : 2));
            end
            checks++;
            if (addrOut !== (p == 0 ? 10'h010 : 10'h020)) begin
                errors++; $display("FAIL rr_addr k=%0d got %h want %h", k, addrOut, (p == 0 ? 10'h010 : 10'h020));
            end
            repeat (3) tick();
            d = 64'hA5A5_0000_0000_0000 + 64'(k);
            dataDownIn = d;
            fetchReceive = 1'b1;
            sb.push_back('{port: p, data: d});
            expUp[p] = d;
            tick();
            fetchReceive = 1'b0;
            checks++;
            if ({complete1, complete0} !== (p == 0 ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL rr_complete k=%0d got %b", k, {complete1, complete0});
            end
            if (p == 0) enableIn0 = 1'b0; else enableIn1 = 1'b0;
            if (k == 2) enableIn1 = 1'b0;
            tick();
            checks++;
            if (enableOut !== 1'b0 || complete0 !== 1'b0 || complete1 !== 1'b0) begin
                errors++; $display("FAIL rr_release k=%0d got en=%b c=%b%b", k, enableOut, complete1, complete0);
            end
            if (k < 2) begin
                if (p == 0) enableIn0 = 1'b1; else enableIn1 = 1'b1;
            end
        end
        repeat (2) tick();
    endtask

    task automatic test_write();
        int wcnt;
        addrIn1 = 10'h008; dataUpIn1 = 64'h0000_0000_FFFF_FFFF;
        writeIn1 = 1'b1; enableIn1 = 1'b1;
        tick();
        writeIn1 = 1'b0;
        checks++;
        if (enableOut !== 1'b1 || writeOut !== 1'b1 || addrOut !== 10'h008 || dataDownOut !== 64'h0000_0000_FFFF_FFFF) begin
            errors++; $display("FAIL write_grant got en=%b wr=%b addr=%h data=%h", enableOut, writeOut, addrOut, dataDownOut);
        end
        dataDownIn = 64'hDEAD_DEAD_DEAD_DEAD;
        fetchReceive = 1'b1;
        tick();
        fetchReceive = 1'b0;
        checks++;
        if (complete1 !== 1'b0 || enableOut !== 1'b1) begin
            errors++; $display("FAIL write_wrong_type got c1=%b en=%b want 0 1", complete1, enableOut);
        end
        wcnt = 0;
        repeat (2) begin tick(); wcnt += complete1; end
        checks++;
        if (wcnt != 0) begin
            errors++; $display("FAIL write_early got complete1 cycles=%0d want 0", wcnt);
        end
        writeCompleteIn = 1'b1;
        sb.push_back('{port: 1, data: expUp[1]});
        tick();
        writeCompleteIn = 1'b0;
        checks++;
        if (complete1 !== 1'b1 || dataUpOut1 !== expUp[1] || enableOut !== 1'b0) begin
            errors++; $display("FAIL write_done got c1=%b d=%h en=%b want 1 %h 0", complete1, dataUpOut1, enableOut, expUp[1]);
        end
        enableIn1 = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_abort();
        int cyc;
        bit ok;
        addrIn0 = 10'h030; writeIn0 = 1'b0; enableIn0 = 1'b1;
        tick();
        checks++;
        if (enableOut !== 1'b1 || addrOut !== 10'h030) begin
            errors++; $display("FAIL abort_grant got en=%b addr=%h want 1 030", enableOut, addrOut);
        end
        addrIn1 = 10'h040; writeIn1 = 1'b0; enableIn1 = 1'b1;
        repeat (2) tick();
        enableIn0 = 1'b0;
        tick();
        checks++;
        if (enableOut !== 1'b0 || complete0 !== 1'b0) begin
            errors++; $display("FAIL abort_drop got en=%b c0=%b want 0 0", enableOut, complete0);
        end
        waitEnable(cyc, ok);
        checks++;
        if (!ok || cyc != 2 || addrOut !== 10'h040) begin
            errors++; $display("FAIL abort_pending got ok=%0d cycles=%0d addr=%h want 1 2 040", ok, cyc, addrOut);
        end
        dataDownIn = 64'hBEEF_0000_1111_2222;
        fetchReceive = 1'b1;
        sb.push_back('{port: 1, data: 64'hBEEF_0000_1111_2222});
        expUp[1] = 64'hBEEF_0000_1111_2222;
        tick();
        fetchReceive = 1'b0;
        checks++;
        if (complete1 !== 1'b1 || complete0 !== 1'b0) begin
            errors++; $display("FAIL abort_port1 got c1=%b c0=%b want 1 0", complete1, complete0);
        end
        enableIn1 = 1'b0;
        repeat (2) tick();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit early;
        addrIn0 = 10'h050; writeIn0 = 1'b0; enableIn0 = 1'b1;
        tick();
        checks++;
        if (enableOut !== 1'b1) begin
            errors++; $display("FAIL timeout_grant got en=%b want 1", enableOut);
        end
        sb.push_back('{port: 0, data: '0});
        expUp[0] = '0;
        early = 1'b0;
        for (int i = 1; i < TO; i++) begin
            tick();
            early |= timeoutErr | complete0;
        end
        checks++;
        if (early) begin
            errors++; $display("FAIL timeout_early got timeoutErr/complete before cycle %0d", TO);
        end
        tick();
        checks++;
        if (timeoutErr !== 1'b1 || complete0 !== 1'b1 || dataUpOut0 !== '0 || enableOut !== 1'b0) begin
            errors++; $display("FAIL timeout_fire got err=%b c0=%b d=%h en=%b want 1 1 0 0", timeoutErr, complete0, dataUpOut0, enableOut);
        end
        tick();
        checks++;
        if (timeoutErr !== 1'b0 || complete0 !== 1'b1) begin
            errors++; $display("FAIL timeout_pulse got err=%b c0=%b want 0 1", timeoutErr, complete0);
        end
        enableIn0 = 1'b0;
        repeat (2) tick();
    endtask
`endif

    task automatic test_reset_mid_busy();
        addrIn0 = 10'h060; writeIn0 = 1'b0; enableIn0 = 1'b1;
        tick();
        checks++;
        if (enableOut !== 1'b1) begin
            errors++; $display("FAIL rstbusy_grant got en=%b want 1", enableOut);
        end
        repeat (2) tick();
        reset = 1'b1;
        enableIn0 = 1'b0;
        tick();
        reset = 1'b0;
        expUp[0] = '0; expUp[1] = '0;
        checks++;
        if ({enableOut, writeOut, complete0, complete1} !== 4'b0 || addrOut !== '0 || dataDownOut !== '0 ||
            dataUpOut0 !== '0 || dataUpOut1 !== '0) begin
            errors++; $display("FAIL rstbusy_zero got en=%b addr=%h up0=%h up1=%h", enableOut, addrOut, dataUpOut0, dataUpOut1);
        end
        dataDownIn = 64'h7777_7777_7777_7777;
        fetchReceive = 1'b1;
        tick();
        fetchReceive = 1'b0;
        tick();
        checks++;
        if (complete0 !== 1'b0 || enableOut !== 1'b0 || dataUpOut0 !== '0) begin
            errors++; $display("FAIL rstbusy_late_fetch got c0=%b en=%b d=%h want 0 0 0", complete0, enableOut, dataUpOut0);
        end
    endtask

    initial begin
        expUp[0] = '0; expUp[1] = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_write();
        test_abort();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_busy();
        repeat (2) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_leftover got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
